// File: rtl/shift_sub_div_pkg.sv
// rtl/shift_sub_div_pkg.sv - shared types and constants for the restoring divider
package shift_sub_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int W_DEF = 4;

    function automatic int cnt_width(input int w);
        return $clog2(2 * w + 1);
    endfunction

endpackage

// File: rtl/div_sub_step.sv
// rtl/div_sub_step.sv - one combinational shift/trial-subtract iteration
module div_sub_step
    import shift_sub_div_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] p,
    input  logic         d_bit,
    input  logic [W-1:0] v,
    output logic [W-1:0] p_next,
    output logic         q_bit
);

    logic [W:0] s;

    assign s     = {p, d_bit};
    assign q_bit = (s >= {1'b0, v});
    // After restoration the remainder is below V, so it always fits in W bits.
    assign p_next = q_bit ? W'(s - {1'b0, v}) : s[W-1:0];

endmodule

// File: rtl/shift_sub_div.sv
// rtl/shift_sub_div.sv - sequential restoring divider, 2W/W bits; DIV_ZERO_DET_EN enables zero-divisor early exit
module shift_sub_div
    import shift_sub_div_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           STRT,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic [2*W-1:0] Q,
    output logic [W-1:0]   R,
    output logic           BUSY,
    output logic           DONE,
    output logic           DIV0
);

    localparam int CW = cnt_width(W);

    state_t         state, state_next;
    logic [2*W-1:0] d_reg;
    logic [W-1:0]   v_reg;
    logic [W-1:0]   p_reg;
    logic [W-1:0]   p_next;
    logic           q_bit;
    logic [CW-1:0]  cnt;
    logic           last_iter;
    logic           zero_skip;
    logic           div0_reg;

    div_sub_step #(.W(W)) u_step (
        .p      (p_reg),
        .d_bit  (d_reg[2*W-1]),
        .v      (v_reg),
        .p_next (p_next),
        .q_bit  (q_bit)
    );

    assign last_iter = (cnt == CW'(2 * W - 1));

`ifdef DIV_ZERO_DET_EN
    assign zero_skip = (v_reg == '0);
`else
    assign zero_skip = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (STRT) state_next = CALC;
            CALC:    if (zero_skip || last_iter) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Quotient bits enter d_reg from the bottom as dividend bits leave the top,
    // so after 2W iterations d_reg holds the quotient.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            d_reg    <= '0;
            v_reg    <= '0;
            p_reg    <= '0;
            cnt      <= '0;
            Q        <= '0;
            R        <= '0;
            div0_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (STRT) begin
                        d_reg <= dividend;
                        v_reg <= divisor;
                        p_reg <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    if (zero_skip) begin
                        Q        <= '1;
                        R        <= d_reg[W-1:0];
                        div0_reg <= 1'b1;
                    end else begin
                        d_reg <= {d_reg[2*W-2:0], q_bit};
                        p_reg <= p_next;
                        cnt   <= cnt + CW'(1);
                        if (last_iter) begin
                            Q        <= {d_reg[2*W-2:0], q_bit};
                            R        <= p_next;
                            div0_reg <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY = (state != IDLE);
    assign DONE = (state == FIN);
    assign DIV0 = div0_reg;

endmodule

// File: tb/tb_shift_sub_div.sv
// tb/tb_shift_sub_div.sv - self-checking bench for shift_sub_div (W=4)
module tb_shift_sub_div;

    localparam int W = 4;
`ifdef DIV_ZERO_DET_EN
    localparam bit DET = 1'b1;
`else
    localparam bit DET = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           RST;
    logic           STRT;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic [2*W-1:0] Q;
    logic [W-1:0]   R;
    logic           BUSY;
    logic           DONE;
    logic           DIV0;

    shift_sub_div #(.W(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .STRT     (STRT),
        .dividend (dividend),
        .divisor  (divisor),
        .Q        (Q),
        .R        (R),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .DIV0     (DIV0)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic           div0;
        int             done_cyc;
    } exp_t;

    typedef struct {
        logic [2*W-1:0] dvd;
        logic [W-1:0]   dvs;
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            exp_t e;
            check("done_not_consecutive", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 (cyc %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("q", {24'd0, Q}, {24'd0, e.q});
                check("r", {28'd0, R}, {28'd0, e.r});
                check("div0", {31'd0, DIV0}, {31'd0, e.div0});
                check("done_latency", cyc, e.done_cyc);
            end
        end
        prev_done <= DONE;
    end

    function automatic int lat(input logic [W-1:0] dvs);
        return (dvs == '0 && DET) ? 1 : 2 * W;
    endfunction

    function automatic exp_t mk(input logic [2*W-1:0] q, input logic [W-1:0] r,
                                input logic [W-1:0] dvs, input int done_cyc);
        exp_t e;
        e.q = q;
        e.r = r;
        e.div0 = (dvs == '0) && DET;
        e.done_cyc = done_cyc;
        return e;
    endfunction

    task automatic start_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                            input logic [2*W-1:0] q, input logic [W-1:0] r);
        dividend = dvd;
        divisor  = dvs;
        STRT     = 1'b1;
        sb.push_back(mk(q, r, dvs, cyc + 1 + lat(dvs)));
        @(negedge CLK);
        STRT = 1'b0;
        check("busy_rise", {31'd0, BUSY}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || BUSY) && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout actual=%0d expected<60", n);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge CLK);
    endtask

    vec_t vecs[7];

    initial begin
        int c;
        int n;
        vecs[0] = '{dvd: 8'd200, dvs: 4'd7,  q: 8'd28,  r: 4'd4};
        vecs[1] = '{dvd: 8'd255, dvs: 4'd15, q: 8'd17,  r: 4'd0};
        vecs[2] = '{dvd: 8'd13,  dvs: 4'd14, q: 8'd0,   r: 4'd13};
        vecs[3] = '{dvd: 8'd0,   dvs: 4'd5,  q: 8'd0,   r: 4'd0};
        vecs[4] = '{dvd: 8'hA5,  dvs: 4'd0,  q: 8'hFF,  r: 4'd5};
        vecs[5] = '{dvd: 8'd255, dvs: 4'd1,  q: 8'd255, r: 4'd0};
        vecs[6] = '{dvd: 8'd1,   dvs: 4'd15, q: 8'd0,   r: 4'd1};

        RST = 1'b0;
        STRT = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(negedge CLK);
        check("rst_q", {24'd0, Q}, 32'd0);
        check("rst_r", {28'd0, R}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_div0", {31'd0, DIV0}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r);
            wait_idle();
            check("done_low_in_idle", {31'd0, DONE}, 32'd0);
        end

        // Back-to-back: second STRT raised during FIN is only taken in IDLE.
        start_op(8'd50, 4'd6, 8'd8, 4'd2);
        n = 0;
        while (DONE !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("b2b_first_done_seen", {31'd0, DONE}, 32'd1);
        dividend = 8'd9;
        divisor  = 4'd9;
        STRT     = 1'b1;
        sb.push_back(mk(8'd1, 4'd0, 4'd9, cyc + 2 + 2 * W));
        @(negedge CLK);
        check("b2b_fin_ignores_strt", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        STRT = 1'b0;
        check("b2b_second_busy", {31'd0, BUSY}, 32'd1);
        repeat (4) @(negedge CLK);
        check("b2b_hold_q", {24'd0, Q}, 32'd8);
        check("b2b_hold_r", {28'd0, R}, 32'd2);
        wait_idle();
        check("b2b_final_q", {24'd0, Q}, 32'd1);
        check("b2b_final_r", {28'd0, R}, 32'd0);

        // STRT held high: one result every 2W+2 edges, operand changes mid-CALC are ignored.
        c = cyc;
        dividend = 8'd200;
        divisor  = 4'd7;
        STRT     = 1'b1;
        sb.push_back(mk(8'd28, 4'd4,  4'd7,  c + 9));
        sb.push_back(mk(8'd17, 4'd0,  4'd15, c + 19));
        sb.push_back(mk(8'd0,  4'd13, 4'd14, c + 29));
        wait_cyc(c + 4);
        dividend = 8'd255;
        divisor  = 4'd15;
        wait_cyc(c + 14);
        dividend = 8'd13;
        divisor  = 4'd14;
        wait_cyc(c + 24);
        STRT = 1'b0;
        wait_idle();

        // Reset asserted before CALC iteration 4.
        c = cyc;
        dividend = 8'd200;
        divisor  = 4'd7;
        STRT     = 1'b1;
        @(negedge CLK);
        STRT = 1'b0;
        wait_cyc(c + 4);
        RST = 1'b0;
        #1;
        check("midrst_q", {24'd0, Q}, 32'd0);
        check("midrst_r", {28'd0, R}, 32'd0);
        check("midrst_busy", {31'd0, BUSY}, 32'd0);
        check("midrst_done", {31'd0, DONE}, 32'd0);
        check("midrst_div0", {31'd0, DIV0}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        start_op(8'd100, 4'd3, 8'd33, 4'd1);
        wait_idle();

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
